// File: rtl/issue_queue_nw.sv
// issue_queue_nw: circular pre-decoded instruction queue between fetch and
// execute. Up to FETCH_W packets enter per cycle and up to ISSUE_W leave per
// cycle as a group whose size follows the pairing rules (single-issue classes,
// intra-group RAW on GPRs and HI/LO, branch/delay-slot placement, load-use).
//
// Handshake: enqueue is accepted for every lane in enq_valid_i on a rising
// edge where enq_ready_o=1 and flush_i=0; otherwise all lanes are dropped and
// the source must hold them. enq_ready_o depends only on the registered count,
// never on enq_valid_i. Issue is offered combinationally on iss_valid_o and is
// consumed at the next rising edge; issue_en_i/stall_i/flush_i gate the offer
// itself, so a presented slot is always a consumed slot.
module issue_queue_nw #(
  parameter int DEPTH   = 8,
  parameter int FETCH_W = 2,
  parameter int ISSUE_W = 2,
  parameter int INFO_W  = 88
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush_i,
  input  logic [FETCH_W-1:0]          enq_valid_i,
  input  logic [FETCH_W*INFO_W-1:0]   enq_info_i,
  output logic                        enq_ready_o,
  input  logic                        issue_en_i,
  input  logic                        stall_i,
  output logic [ISSUE_W-1:0]          iss_valid_o,
  output logic [ISSUE_W*INFO_W-1:0]   iss_info_o,
  output logic [ISSUE_W-1:0]          iss_delayslot_o,
  output logic                        stallreq_o,
  output logic [$clog2(DEPTH):0]      count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Packet field positions, counted from the LSB end of the packet.
  localparam int B_HILO_WE = 1;
  localparam int B_HILO_RE = 2;
  localparam int B_LOAD    = 3;
  localparam int B_JB      = 4;
  localparam int B_SINGLE  = 5;
  localparam int B_WE      = 6;
  localparam int B_RT_RE   = 7;
  localparam int B_RS_RE   = 8;
  localparam int WA_LO     = 9;
  localparam int RT_LO     = 14;
  localparam int RS_LO     = 19;

  logic [INFO_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ds_pending_q, ds_pending_d;
  logic              lu_valid_q, lu_valid_d;
  logic [4:0]        lu_addr_q, lu_addr_d;

  logic [PTR_W-1:0]  cand_idx  [ISSUE_W];
  logic [INFO_W-1:0] cand_info [ISSUE_W];
  logic [ISSUE_W-1:0] cand_present;
  logic [ISSUE_W-1:0] iss_v;
  logic              slot_ok;
  logic              lu_hit;
  logic              enq_ready;
  logic              do_enq;
  logic [CNT_W-1:0]  enq_cnt, deq_cnt;
  logic              any_iss, last_jb, lu_found;
  logic [4:0]        lu_found_addr;

  // Candidate k is the k-th oldest entry, present only while count covers it.
  for (genvar g = 0; g < ISSUE_W; g++) begin : g_cand
    assign cand_idx[g]     = head_q + PTR_W'(g);
    assign cand_info[g]    = mem_q[cand_idx[g]];
    assign cand_present[g] = count_q > CNT_W'(g);
  end

  // Head instruction reads the destination of a load issued last cycle.
  assign lu_hit = lu_valid_q && (lu_addr_q != 5'd0) &&
                  ((cand_info[0][B_RS_RE] && (cand_info[0][RS_LO +: 5] == lu_addr_q)) ||
                   (cand_info[0][B_RT_RE] && (cand_info[0][RT_LO +: 5] == lu_addr_q)));

  // Room for a full fetch bundle, judged before this cycle's dequeue.
  assign enq_ready = (CNT_W'(DEPTH) - count_q) >= CNT_W'(FETCH_W);
  assign do_enq    = enq_ready && !flush_i;

  // Group formation: each slot joins only if every earlier slot joined.
  always_comb begin
    iss_v    = '0;
    slot_ok  = 1'b0;
    iss_v[0] = cand_present[0] && issue_en_i && !stall_i && !flush_i && !lu_hit;
    for (int k = 1; k < ISSUE_W; k++) begin
      slot_ok = iss_v[k-1] && cand_present[k] && !ds_pending_q && !cand_info[0][B_SINGLE];
      // Single-issue and branch instructions may only ride as a delay slot.
      if ((cand_info[k][B_SINGLE] || cand_info[k][B_JB]) && !cand_info[k-1][B_JB])
        slot_ok = 1'b0;
      for (int j = 0; j < ISSUE_W; j++) begin
        if (j < k) begin
          // The group closes right after a branch's delay slot.
          if (cand_info[j][B_JB] && (j + 1 < k))
            slot_ok = 1'b0;
          if (cand_info[j][B_WE] && (cand_info[j][WA_LO +: 5] != 5'd0) &&
              ((cand_info[k][B_RS_RE] && (cand_info[k][RS_LO +: 5] == cand_info[j][WA_LO +: 5])) ||
               (cand_info[k][B_RT_RE] && (cand_info[k][RT_LO +: 5] == cand_info[j][WA_LO +: 5]))))
            slot_ok = 1'b0;
          if (cand_info[j][B_HILO_WE] && cand_info[k][B_HILO_RE])
            slot_ok = 1'b0;
        end
      end
      iss_v[k] = slot_ok;
    end
  end

  // Per-cycle summaries of the enqueue bundle and the issued group.
  always_comb begin
    enq_cnt       = '0;
    deq_cnt       = '0;
    any_iss       = 1'b0;
    last_jb       = 1'b0;
    lu_found      = 1'b0;
    lu_found_addr = 5'd0;
    for (int k = 0; k < FETCH_W; k++)
      enq_cnt = enq_cnt + CNT_W'(enq_valid_i[k]);
    for (int k = 0; k < ISSUE_W; k++) begin
      deq_cnt = deq_cnt + CNT_W'(iss_v[k]);
      if (iss_v[k]) begin
        any_iss = 1'b1;
        last_jb = cand_info[k][B_JB];
        if (cand_info[k][B_LOAD] && cand_info[k][B_WE]) begin
          lu_found      = 1'b1;
          lu_found_addr = cand_info[k][WA_LO +: 5];
        end
      end
    end
  end

  // Next-state for pointers, occupancy, delay-slot and load-use tracking.
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    ds_pending_d = ds_pending_q;
    lu_valid_d   = lu_valid_q;
    lu_addr_d    = lu_addr_q;
    if (flush_i) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      ds_pending_d = 1'b0;
      lu_valid_d   = 1'b0;
    end else begin
      head_d  = head_q + deq_cnt[PTR_W-1:0];
      if (do_enq)
        tail_d = tail_q + enq_cnt[PTR_W-1:0];
      count_d = count_q + (do_enq ? enq_cnt : '0) - deq_cnt;
      if (any_iss)
        ds_pending_d = last_jb;
      // A stalled pipeline keeps the load in flight, so the tracker holds.
      if (!stall_i) begin
        if (any_iss) begin
          lu_valid_d = lu_found;
          lu_addr_d  = lu_found_addr;
        end else begin
          lu_valid_d = 1'b0;
        end
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      ds_pending_q <= 1'b0;
      lu_valid_q   <= 1'b0;
      lu_addr_q    <= 5'd0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      ds_pending_q <= ds_pending_d;
      lu_valid_q   <= lu_valid_d;
      lu_addr_q    <= lu_addr_d;
    end
  end

  // Packet storage; lanes land in consecutive slots starting at tail.
  always_ff @(posedge clk) begin
    for (int k = 0; k < FETCH_W; k++) begin
      if (do_enq && enq_valid_i[k])
        mem_q[tail_q + PTR_W'(k)] <= enq_info_i[k*INFO_W +: INFO_W];
    end
  end

  for (genvar g = 0; g < ISSUE_W; g++) begin : g_out
    assign iss_info_o[g*INFO_W +: INFO_W] = iss_v[g] ? cand_info[g] : '0;
    if (g == 0) begin : g_ds0
      assign iss_delayslot_o[g] = iss_v[g] && ds_pending_q;
    end else begin : g_dsk
      assign iss_delayslot_o[g] = iss_v[g] && cand_info[g-1][B_JB];
    end
  end

  assign iss_valid_o = iss_v;
  assign stallreq_o  = cand_present[0] && lu_hit && !stall_i;
  assign enq_ready_o = enq_ready;
  assign count_o     = count_q;

endmodule

// File: tb/tb_issue_queue_nw.sv
// Bench for issue_queue_nw: directed scenarios with known answers, then a
// randomized stream checked against a packet-queue reference model.
module tb_issue_queue_nw;

  localparam int DEPTH   = 8;
  localparam int FETCH_W = 2;
  localparam int ISSUE_W = 2;
  localparam int INFO_W  = 88;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      flush_i;
  logic [FETCH_W-1:0]        enq_valid_i;
  logic [FETCH_W*INFO_W-1:0] enq_info_i;
  logic                      enq_ready_o;
  logic                      issue_en_i;
  logic                      stall_i;
  logic [ISSUE_W-1:0]        iss_valid_o;
  logic [ISSUE_W*INFO_W-1:0] iss_info_o;
  logic [ISSUE_W-1:0]        iss_delayslot_o;
  logic                      stallreq_o;
  logic [3:0]                count_o;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [INFO_W-1:0] model_q[$];
  logic [INFO_W-1:0] exp_q[$];
  logic              m_ds;
  logic              m_lu_v;
  logic [4:0]        m_lu_a;

  issue_queue_nw #(.DEPTH(DEPTH), .FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .INFO_W(INFO_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .enq_valid_i(enq_valid_i), .enq_info_i(enq_info_i), .enq_ready_o(enq_ready_o),
    .issue_en_i(issue_en_i), .stall_i(stall_i),
    .iss_valid_o(iss_valid_o), .iss_info_o(iss_info_o),
    .iss_delayslot_o(iss_delayslot_o), .stallreq_o(stallreq_o), .count_o(count_o)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Packet builders
  function automatic logic [87:0] mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] wa,
                                      input logic rs_re, input logic rt_re, input logic we,
                                      input logic single, input logic jb, input logic load,
                                      input logic hr, input logic hw);
    logic [31:0] pc;
    logic [31:0] inst;
    pc   = $urandom;
    inst = $urandom;
    return {pc, inst, rs, rt, wa, rs_re, rt_re, we, single, jb, load, hr, hw, 1'b0};
  endfunction

  function automatic logic [87:0] addu(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, rd, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [87:0] mthi(input logic [4:0] rs);
    return mk(rs, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction
  function automatic logic [87:0] mfhi(input logic [4:0] rd);
    return mk(5'd0, 5'd0, rd, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction
  function automatic logic [87:0] beq(input logic [4:0] rs, input logic [4:0] rt);
    return mk(rs, rt, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [87:0] nop();
    return mk(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction
  function automatic logic [87:0] lw(input logic [4:0] rt, input logic [4:0] base);
    return mk(base, 5'd0, rt, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // Field views used by the reference model
  function automatic logic f_jb(input logic [87:0] p);     return p[4]; endfunction
  function automatic logic f_single(input logic [87:0] p); return p[5]; endfunction
  function automatic logic f_load(input logic [87:0] p);   return p[3]; endfunction
  function automatic logic f_we(input logic [87:0] p);     return p[6]; endfunction
  function automatic logic f_hr(input logic [87:0] p);     return p[2]; endfunction
  function automatic logic f_hw(input logic [87:0] p);     return p[1]; endfunction
  function automatic logic [4:0] f_wa(input logic [87:0] p); return p[13:9]; endfunction
  function automatic logic reads(input logic [87:0] p, input logic [4:0] r);
    return (p[8] && p[23:19] == r) || (p[7] && p[18:14] == r);
  endfunction

  // Can the k-th oldest model entry join the group formed by entries 0..k-1?
  function automatic logic joins(input int k);
    if (m_ds || f_single(model_q[0])) return 1'b0;
    if ((f_single(model_q[k]) || f_jb(model_q[k])) && !f_jb(model_q[k-1])) return 1'b0;
    for (int j = 0; j < k; j++) begin
      if (f_jb(model_q[j]) && j + 1 < k) return 1'b0;
      if (f_we(model_q[j]) && f_wa(model_q[j]) != 5'd0 && reads(model_q[k], f_wa(model_q[j]))) return 1'b0;
      if (f_hw(model_q[j]) && f_hr(model_q[k])) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive_enq(input logic [1:0] m, input logic [87:0] a, input logic [87:0] b);
    enq_valid_i = m;
    enq_info_i  = {b, a};
    tick();
    enq_valid_i = '0;
    enq_info_i  = '0;
  endtask

  task automatic test_reset();
    rst = 1'b0; flush_i = 1'b0; enq_valid_i = '0; enq_info_i = '0;
    issue_en_i = 1'b0; stall_i = 1'b0;
    #12;
    checks++; if (enq_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", enq_ready_o); end
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    checks++; if (iss_valid_o !== 2'b00 || iss_delayslot_o !== 2'b00 || stallreq_o !== 1'b0 || iss_info_o !== '0)
      begin errors++; $display("FAIL reset_outputs valid=%b ds=%b stallreq=%b exp all zero", iss_valid_o, iss_delayslot_o, stallreq_o); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_independent();
    logic [87:0] a, b;
    a = addu(5'd1, 5'd2, 5'd3);
    b = addu(5'd4, 5'd5, 5'd6);
    drive_enq(2'b11, a, b);
    checks++; if (count_o !== 4'd2) begin errors++; $display("FAIL indep_count_fill got=%0d exp=2", count_o); end
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b11) begin errors++; $display("FAIL indep_valid got=%b exp=11", iss_valid_o); end
    checks++; if (iss_info_o !== {b, a}) begin errors++; $display("FAIL indep_info got=%h exp=%h", iss_info_o, {b, a}); end
    tick();
    issue_en_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL indep_count_drain got=%0d exp=0", count_o); end
  endtask

  task automatic test_raw();
    drive_enq(2'b11, addu(5'd1, 5'd2, 5'd3), addu(5'd7, 5'd1, 5'd2));
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL raw_gpr_first got=%b exp=01", iss_valid_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL raw_gpr_second got=%b exp=01", iss_valid_o); end
    tick();
    issue_en_i = 1'b0;
    drive_enq(2'b11, mthi(5'd3), mfhi(5'd5));
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL raw_hilo_first got=%b exp=01", iss_valid_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL raw_hilo_second got=%b exp=01", iss_valid_o); end
    tick();
    issue_en_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL raw_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_branch();
    drive_enq(2'b11, addu(5'd1, 5'd2, 5'd3), beq(5'd2, 5'd3));
    drive_enq(2'b01, nop(), '0);
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL br_slot1_valid got=%b exp=01", iss_valid_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b11) begin errors++; $display("FAIL br_pair_valid got=%b exp=11", iss_valid_o); end
    checks++; if (iss_delayslot_o !== 2'b10) begin errors++; $display("FAIL br_pair_ds got=%b exp=10", iss_delayslot_o); end
    tick();
    issue_en_i = 1'b0;
    drive_enq(2'b01, beq(5'd4, 5'd0), '0);
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b01 || iss_delayslot_o !== 2'b00)
      begin errors++; $display("FAIL br_alone valid=%b ds=%b exp 01/00", iss_valid_o, iss_delayslot_o); end
    tick();
    issue_en_i = 1'b0;
    drive_enq(2'b11, addu(5'd10, 5'd1, 5'd1), addu(5'd11, 5'd2, 5'd2));
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL br_pending_valid got=%b exp=01", iss_valid_o); end
    checks++; if (iss_delayslot_o !== 2'b01) begin errors++; $display("FAIL br_pending_ds got=%b exp=01", iss_delayslot_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b01 || iss_delayslot_o !== 2'b00)
      begin errors++; $display("FAIL br_after_ds valid=%b ds=%b exp 01/00", iss_valid_o, iss_delayslot_o); end
    tick();
    issue_en_i = 1'b0;
  endtask

  task automatic test_load_use();
    drive_enq(2'b11, lw(5'd8, 5'd2), addu(5'd9, 5'd8, 5'd0));
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b01 || stallreq_o !== 1'b0)
      begin errors++; $display("FAIL lu_load valid=%b stallreq=%b exp 01/0", iss_valid_o, stallreq_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b00 || stallreq_o !== 1'b1)
      begin errors++; $display("FAIL lu_hazard valid=%b stallreq=%b exp 00/1", iss_valid_o, stallreq_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b01 || stallreq_o !== 1'b0)
      begin errors++; $display("FAIL lu_release valid=%b stallreq=%b exp 01/0", iss_valid_o, stallreq_o); end
    tick();
    issue_en_i = 1'b0;
    drive_enq(2'b11, lw(5'd8, 5'd2), addu(5'd9, 5'd8, 5'd0));
    issue_en_i = 1'b1;
    tick();
    stall_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b00 || stallreq_o !== 1'b0)
      begin errors++; $display("FAIL lu_stalled valid=%b stallreq=%b exp 00/0", iss_valid_o, stallreq_o); end
    tick();
    stall_i = 1'b0;
    #1;
    checks++; if (iss_valid_o !== 2'b00 || stallreq_o !== 1'b1)
      begin errors++; $display("FAIL lu_held valid=%b stallreq=%b exp 00/1", iss_valid_o, stallreq_o); end
    tick();
    checks++; if (iss_valid_o !== 2'b01) begin errors++; $display("FAIL lu_held_release got=%b exp=01", iss_valid_o); end
    tick();
    issue_en_i = 1'b0;
  endtask

  task automatic test_full_wrap();
    logic [87:0] p[8];
    logic [87:0] q0, q1;
    for (int i = 0; i < 8; i++)
      p[i] = mk(5'd0, 5'd0, 5'(i + 1), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    q0 = mk(5'd0, 5'd0, 5'd20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    q1 = mk(5'd0, 5'd0, 5'd21, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      drive_enq(2'b11, p[2*i], p[2*i+1]);
    checks++; if (count_o !== 4'd8 || enq_ready_o !== 1'b0)
      begin errors++; $display("FAIL full_state count=%0d ready=%b exp 8/0", count_o, enq_ready_o); end
    enq_valid_i = 2'b11; enq_info_i = {q1, q0}; issue_en_i = 1'b1;
    #1;
    checks++; if (enq_ready_o !== 1'b0 || iss_valid_o !== 2'b11)
      begin errors++; $display("FAIL full_simul ready=%b valid=%b exp 0/11", enq_ready_o, iss_valid_o); end
    tick();
    issue_en_i = 1'b0;
    #1;
    checks++; if (count_o !== 4'd6 || enq_ready_o !== 1'b1)
      begin errors++; $display("FAIL full_dropped count=%0d ready=%b exp 6/1", count_o, enq_ready_o); end
    tick();
    enq_valid_i = '0; enq_info_i = '0;
    checks++; if (count_o !== 4'd8) begin errors++; $display("FAIL full_accepted count=%0d exp=8", count_o); end
    exp_q.delete();
    for (int i = 2; i < 8; i++) exp_q.push_back(p[i]);
    exp_q.push_back(q0);
    exp_q.push_back(q1);
    issue_en_i = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      checks++; if (iss_info_o !== {exp_q[1], exp_q[0]})
        begin errors++; $display("FAIL wrap_order step=%0d got=%h exp=%h", c, iss_info_o, {exp_q[1], exp_q[0]}); end
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      tick();
    end
    issue_en_i = 1'b0;
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL wrap_count got=%0d exp=0", count_o); end
  endtask

  task automatic test_flush();
    drive_enq(2'b11, addu(5'd1, 5'd0, 5'd0), addu(5'd2, 5'd0, 5'd0));
    drive_enq(2'b11, addu(5'd3, 5'd0, 5'd0), addu(5'd4, 5'd0, 5'd0));
    drive_enq(2'b01, addu(5'd5, 5'd0, 5'd0), '0);
    checks++; if (count_o !== 4'd5) begin errors++; $display("FAIL flush_fill count=%0d exp=5", count_o); end
    flush_i = 1'b1; issue_en_i = 1'b1;
    enq_valid_i = 2'b11; enq_info_i = {addu(5'd6, 5'd0, 5'd0), addu(5'd7, 5'd0, 5'd0)};
    #1;
    checks++; if (iss_valid_o !== 2'b00) begin errors++; $display("FAIL flush_noissue got=%b exp=00", iss_valid_o); end
    tick();
    flush_i = 1'b0; issue_en_i = 1'b0; enq_valid_i = '0; enq_info_i = '0;
    #1;
    checks++; if (count_o !== 4'd0 || enq_ready_o !== 1'b1)
      begin errors++; $display("FAIL flush_state count=%0d ready=%b exp 0/1", count_o, enq_ready_o); end
    tick();
  endtask

  task automatic test_random();
    logic [87:0] lane0, lane1;
    logic [1:0]  e_valid, e_ds;
    logic [ISSUE_W*INFO_W-1:0] e_info;
    logic e_ready, e_haz, e_sreq;
    int n_en, n_iss;
    model_q.delete();
    m_ds = 1'b0; m_lu_v = 1'b0; m_lu_a = 5'd0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      n_en  = $urandom_range(0, 2);
      lane0 = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      lane1 = mk(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0);
      enq_valid_i = 2'((1 << n_en) - 1);
      enq_info_i  = {lane1, lane0};
      issue_en_i  = $urandom_range(0, 9) != 0;
      stall_i     = $urandom_range(0, 7) == 0;
      flush_i     = $urandom_range(0, 49) == 0;
      #1;
      e_ready = (DEPTH - model_q.size()) >= FETCH_W;
      e_haz   = model_q.size() > 0 && m_lu_v && m_lu_a != 5'd0 && reads(model_q[0], m_lu_a);
      e_sreq  = model_q.size() > 0 && e_haz && !stall_i;
      n_iss   = 0;
      if (model_q.size() > 0 && issue_en_i && !stall_i && !flush_i && !e_haz) begin
        n_iss = 1;
        while (n_iss < ISSUE_W && n_iss < model_q.size() && joins(n_iss)) n_iss++;
      end
      e_valid = 2'((1 << n_iss) - 1);
      e_ds    = '0;
      e_info  = '0;
      for (int k = 0; k < n_iss; k++) begin
        e_ds[k] = (k == 0) ? m_ds : f_jb(model_q[k-1]);
        e_info[k*INFO_W +: INFO_W] = model_q[k];
      end
      checks++; if (iss_valid_o !== e_valid) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, iss_valid_o, e_valid); end
      checks++; if (iss_delayslot_o !== e_ds) begin errors++; $display("FAIL rnd_ds cyc=%0d got=%b exp=%b", cyc, iss_delayslot_o, e_ds); end
      checks++; if (iss_info_o !== e_info) begin errors++; $display("FAIL rnd_info cyc=%0d got=%h exp=%h", cyc, iss_info_o, e_info); end
      checks++; if (stallreq_o !== e_sreq) begin errors++; $display("FAIL rnd_stallreq cyc=%0d got=%b exp=%b", cyc, stallreq_o, e_sreq); end
      checks++; if (enq_ready_o !== e_ready) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, enq_ready_o, e_ready); end
      checks++; if (count_o !== 4'(model_q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count_o, model_q.size()); end
      tick();
      if (flush_i) begin
        model_q.delete();
        m_ds = 1'b0; m_lu_v = 1'b0;
      end else begin
        if (n_iss > 0) m_ds = f_jb(model_q[n_iss-1]);
        if (!stall_i) begin
          m_lu_v = 1'b0;
          for (int k = 0; k < n_iss; k++)
            if (f_load(model_q[k]) && f_we(model_q[k])) begin m_lu_v = 1'b1; m_lu_a = f_wa(model_q[k]); end
        end
        for (int k = 0; k < n_iss; k++) void'(model_q.pop_front());
        if (e_ready) begin
          if (n_en >= 1) model_q.push_back(lane0);
          if (n_en >= 2) model_q.push_back(lane1);
        end
      end
    end
    enq_valid_i = '0; enq_info_i = '0; issue_en_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic test_async_reset();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    drive_enq(2'b11, addu(5'd1, 5'd2, 5'd3), addu(5'd4, 5'd5, 5'd6));
    issue_en_i = 1'b1;
    #1;
    checks++; if (iss_valid_o !== 2'b11) begin errors++; $display("FAIL areset_pre got=%b exp=11", iss_valid_o); end
    rst = 1'b0;
    #1;
    checks++; if (iss_valid_o !== 2'b00 || iss_info_o !== '0 || count_o !== 4'd0 || enq_ready_o !== 1'b1)
      begin errors++; $display("FAIL areset_now valid=%b count=%0d ready=%b exp 00/0/1", iss_valid_o, count_o, enq_ready_o); end
    #1;
    rst = 1'b1;
    issue_en_i = 1'b0;
    tick();
    checks++; if (count_o !== 4'd0) begin errors++; $display("FAIL areset_after count=%0d exp=0", count_o); end
  endtask

  initial begin
    test_reset();
    test_independent();
    test_raw();
    test_branch();
    test_load_use();
    test_full_wrap();
    test_flush();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/issue_queue_nw.md
Name: issue_queue_nw

Overview:
- Parametrised successor of the dual-issue decode/issue stage.
- A circular instruction queue between fetch and execute. It accepts up to FETCH_W pre-decoded instructions per cycle and issues up to ISSUE_W per cycle.
- Decides issue group size from pairing rules (single-issue classes, intra-group RAW on GPR and HI/LO, branch/delay-slot placement, load-use interlock).
- Holds delay-slot and load-use state across cycles.

Parameters:
- DEPTH, 8, queue entries (power of 2, ≥ max(FETCH_W, ISSUE_W)).
- FETCH_W, 2, enqueue lanes (1..4).
- ISSUE_W, 2, issue slots (1..4).
- INFO_W, 88, packet width. Fields, MSB first: pc[32], inst[32], rs[5], rt[5], waddr[5], rs_re, rt_re, we, single, jb, load, hilo_re, hilo_we, rsv[1].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-low.
- flush_i  in  1  discard all queued and tracked state.
- enq_valid_i  in  FETCH_W  lane-valid mask; contiguous from bit 0.
- enq_info_i  in  FETCH_W*INFO_W  lane k at bits [k*INFO_W +: INFO_W].
- enq_ready_o  out  1  queue can take FETCH_W entries this cycle.
- issue_en_i  in  1  downstream can accept a group.
- stall_i  in  1  stall from ex/dcache; blocks all issue.
- iss_valid_o  out  ISSUE_W  issued-slot mask; contiguous from bit 0.
- iss_info_o  out  ISSUE_W*INFO_W  slot packets; zero where not valid.
- iss_delayslot_o  out  ISSUE_W  slot k is a delay-slot instruction.
- stallreq_o  out  1  head present but blocked by load-use.
- count_o  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst=0, async): head=tail=0, count=0, ds_pending=0, lu_valid=0. All outputs 0 except enq_ready_o=1.
- Enqueue:
  - enq_ready_o = (DEPTH − count ≥ FETCH_W), computed from pre-dequeue count.
  - When ready, all valid lanes are written at tail, tail+1, … (mod DEPTH), and tail advances by popcount(enq_valid_i).
  - When not ready, all lanes are dropped; the source must hold them.
- Candidates: slot k = entry (head+k) mod DEPTH, for k < min(count, ISSUE_W). Outputs are combinational from queue state; dequeue happens at the edge.
- Slot 0 issues iff all of:
  - candidate present;
  - issue_en_i=1;
  - stall_i=0;
  - flush_i=0;
  - no load-use hazard.
- Load-use hazard: lu_valid and ((rs_re and rs==lu_addr) or (rt_re and rt==lu_addr)), where lu_addr≠0.
- Slot k>0 issues iff all of:
  - slot k−1 issued;
  - ds_pending=0;
  - slot 0 single=0;
  - slot k single=0 and jb=0, unless slot k−1 is jb (delay-slot slot);
  - no slot j<k is a jb whose delay slot j+1 < k (the group ends after the delay slot);
  - no RAW: for every j<k with we_j, waddr_j≠0, and (rs_re_k and rs_k==waddr_j or rt_re_k and rt_k==waddr_j);
  - not (hilo_we of any j<k and hilo_re_k).
- Delay-slot marking:
  - iss_delayslot_o[k]=1 if k>0 and slot k−1 is jb.
  - iss_delayslot_o[0]=1 if ds_pending=1.
  - If the last issued slot is jb, set ds_pending=1 next cycle. Otherwise, any issue clears ds_pending.
- Load-use tracker:
  - lu_valid/lu_addr capture the highest issued slot with load=1 and we=1.
  - Cleared when nothing issues in a cycle where stall_i=0.
  - Held while stall_i=1.
- stallreq_o = candidate 0 present and load-use hazard, gated by stall_i=0.
- Dequeue: head += popcount(iss_valid_o). count' = count + enq − deq, within 0..DEPTH.
- Wrap-around: pointers are modulo DEPTH. A full queue with simultaneous dequeue still reports enq_ready_o from pre-dequeue count.
- Flush:
  - Next state head=tail=count=0; ds_pending=0; lu_valid=0.
  - Same-cycle enqueue is dropped.
  - iss_valid_o=0 that cycle.
- ISSUE_W=1: only slot-0 rules apply. A branch always sets ds_pending.

Test Plan:
- Independent stream: ISSUE_W=2; enqueue addu $1,$2,$3 and addu $4,$5,$6 → iss_valid_o=2'b11 next cycle; count_o 2→0.
- Intra-group RAW: addu $1,… then subu $7,$1,$2 → iss_valid_o=2'b01, then 2'b01; likewise mthi followed by mfhi.
- Branch placement:
  - beq at slot 1 → only slot 0 issues.
  - Next cycle beq+nop at slots 0/1 → iss_valid_o=2'b11, iss_delayslot_o=2'b10.
  - beq with empty slot 1 → ds_pending=1; next issue iss_valid_o=2'b01, iss_delayslot_o=2'b01.
- Load-use: lw $8 issued, then addu $9,$8,$0 at head → stallreq_o=1 for one cycle, then issues; with stall_i=1 inserted, the hazard persists.
- Full/wrap: DEPTH=8, fill 8 entries (enq_ready_o=0, count_o=8); issue 2 plus enqueue 2 in the same cycle → enqueue dropped; next cycle accepted; pointers wrap correctly.
- Flush and reset: flush_i with count=5 and enqueue valid → count_o=0, iss_valid_o=0. Assert rst=0 mid-issue → outputs zero immediately (async).
